fusion_inst_queue: RTL and testbench

Instruction queue between the fetch stage and the macro-op fusion decoder. It buffers fetched instructions with their PCs and presents the two oldest entries as a head pair (slot 0 = decode instruction, slot 1 = the next instruction) so the fusion decoder can check for a fusible sequence. Each accepted cycle retires one entry, or two when the decoder reports a fusion, so a fused pair leaves the queue in a single cycle. It also keeps a count of fused pairs for performance monitoring.

---
 rtl/fusion_inst_queue.sv | 87 ++++++++
 tb/tb_fusion_inst_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fusion_inst_queue.sv
// Instruction queue feeding the macro-op fusion decoder: presents the two oldest
// entries as a head pair and retires one or two entries per accepted cycle.
module fusion_inst_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [31:0]                in_pc,
  output logic                       out_valid0,
  output logic [31:0]                out_inst0,
  output logic [31:0]                out_pc0,
  output logic                       out_valid1,
  output logic [31:0]                out_inst1,
  output logic [31:0]                out_pc1,
  input  logic                       deq_ready,
  input  logic                       fuse_flag,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                fuse_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_nxt1;
  logic [CW-1:0] count_q;
  logic [31:0]   fuse_count_q;
  logic          push;
  logic [1:0]    pop_n;

  assign count       = count_q;
  assign fuse_count  = fuse_count_q;
  assign in_ready    = !flush && (count_q != CW'(DEPTH));
  assign push        = in_valid && in_ready;
  assign rd_ptr_nxt1 = rd_ptr + PW'(1);

  assign out_valid0 = (count_q != '0);
  assign out_valid1 = (count_q >= CW'(2));
  assign out_inst0  = out_valid0 ? inst_mem[rd_ptr]      : NOP_INST;
  assign out_pc0    = out_valid0 ? pc_mem[rd_ptr]        : 32'h0;
  assign out_inst1  = out_valid1 ? inst_mem[rd_ptr_nxt1] : NOP_INST;
  assign out_pc1    = out_valid1 ? pc_mem[rd_ptr_nxt1]   : 32'h0;

  // A fuse request without a second valid entry degrades to a single pop.
  always_comb begin
    pop_n = 2'd0;
    if (deq_ready && out_valid0)
      pop_n = (fuse_flag && out_valid1) ? 2'd2 : 2'd1;
  end

  // Storage is left uncleared by reset and flush; valid tracking lives in count.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
      fuse_count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(pop_n);
      count_q <= count_q + CW'(push) - CW'(pop_n);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop_n == 2'd2)
        fuse_count_q <= fuse_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_fusion_inst_queue.sv
// Bench for fusion_inst_queue: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_fusion_inst_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, deq_ready, fuse_flag;
  logic [31:0] in_inst, in_pc;
  logic        out_valid0, out_valid1;
  logic [31:0] out_inst0, out_pc0, out_inst1, out_pc1;
  logic [2:0]  count;
  logic [31:0] fuse_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  logic [31:0] m_fuse = 0;

  fusion_inst_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid0(out_valid0), .out_inst0(out_inst0), .out_pc0(out_pc0),
    .out_valid1(out_valid1), .out_inst1(out_inst1), .out_pc1(out_pc1),
    .deq_ready(deq_ready), .fuse_flag(fuse_flag),
    .count(count), .fuse_count(fuse_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz = mq.size();
    chk("in_ready",   32'(in_ready),   32'(!flush && sz != DEPTH));
    chk("count",      32'(count),      32'(sz));
    chk("out_valid0", 32'(out_valid0), 32'(sz >= 1));
    chk("out_valid1", 32'(out_valid1), 32'(sz >= 2));
    chk("out_inst0",  out_inst0, (sz >= 1) ? mq[0][63:32] : NOP);
    chk("out_pc0",    out_pc0,   (sz >= 1) ? mq[0][31:0]  : 32'h0);
    chk("out_inst1",  out_inst1, (sz >= 2) ? mq[1][63:32] : NOP);
    chk("out_pc1",    out_pc1,   (sz >= 2) ? mq[1][31:0]  : 32'h0);
    chk("fuse_count", fuse_count, m_fuse);
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic fl, input logic iv, input logic [31:0] ii,
                       input logic [31:0] ip, input logic dq, input logic fu);
    int  sz;
    int  n;
    logic acc;
    flush = fl; in_valid = iv; in_inst = ii; in_pc = ip;
    deq_ready = dq; fuse_flag = fu;
    @(negedge clk);
    check_model();
    sz  = mq.size();
    acc = iv && !fl && (sz != DEPTH);
    if (fl) begin
      mq.delete();
    end else begin
      n = 0;
      if (dq && sz >= 1) n = (fu && sz >= 2) ? 2 : 1;
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (n == 2) m_fuse++;
      if (acc) mq.push_back({ii, ip});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 0; in_pc = 0;
    deq_ready = 1'b0; fuse_flag = 1'b0;
    #12;
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid0", 32'(out_valid0), 32'd0);
    chk("rst_out_inst0",  out_inst0,       NOP);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full, then a rejected fifth push
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h1000 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
    chk("fill_count", 32'(count),    32'd4);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_pc0",   out_pc0,       32'h0);
    chk("fill_pc1",   out_pc1,       32'h4);
    cycle(1'b0, 1'b1, 32'hdead, 32'h10, 1'b0, 1'b0);
    chk("full_reject_count", 32'(count), 32'd4);

    // Single pop
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop1_count", 32'(count), 32'd3);
    chk("pop1_pc0",   out_pc0,    32'h4);
    chk("pop1_pc1",   out_pc1,    32'h8);

    // Fused LUI/ADDI pair
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h123452b7, 32'h10, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h12328293, 32'h14, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h00728333, 32'h18, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("fuse_count_q", 32'(count), 32'd1);
    chk("fuse_pc0",     out_pc0,    32'h18);
    chk("fuse_cnt1",    fuse_count, 32'd1);

    // Fuse request with one entry
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("fuse1_count", 32'(count),      32'd0);
    chk("fuse1_fcnt",  fuse_count,      32'd1);
    chk("fuse1_v0",    32'(out_valid0), 32'd0);

    // rd_ptr now 3: push two, then push while fusing across the wrap
    cycle(1'b0, 1'b1, 32'h2000, 32'h20, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h2004, 32'h24, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h2040, 32'h40, 1'b1, 1'b1);
    chk("wrap_count", 32'(count), 32'd1);
    chk("wrap_pc0",   out_pc0,    32'h40);
    chk("wrap_fcnt",  fuse_count, 32'd2);

    // Flush with concurrent push and pop
    cycle(1'b0, 1'b1, 32'h3000, 32'h50, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h3004, 32'h54, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h3008, 32'h58, 1'b1, 1'b1);
    chk("flush_count", 32'(count),      32'd0);
    chk("flush_v0",    32'(out_valid0), 32'd0);
    chk("flush_fcnt",  fuse_count,      32'd2);

    // Refill and assert reset between edges
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h4000 + 32'(i), 32'h60 + 32'(4 * i), 1'b0, 1'b0);
    in_valid = 1'b0; deq_ready = 1'b0; fuse_flag = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("arst_count", 32'(count),      32'd0);
    chk("arst_fcnt",  fuse_count,      32'd0);
    chk("arst_v0",    32'(out_valid0), 32'd0);
    #1 rst_n = 1'b1;
    mq.delete();
    m_fuse = 0;
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 24) == 0, ($urandom % 4) != 0, $urandom, $urandom & 32'hffff_fffc,
            ($urandom % 3) != 0, ($urandom % 2) == 0);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
